// File: rtl/fir_root_pkg.sv
// Shared types and constants for the FIR -> ROOT sequencer slice.
package fir_root_pkg;

    localparam int TAPS = 7;
    localparam int DW   = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic [DW-1:0] coef_t;

endpackage

// File: rtl/fir_root_vld_pipe.sv
// Tag delay line: marks which datapath outputs belong to real samples.
module fir_root_vld_pipe #(
    parameter int PIPE_LAT = 4
) (
    input  logic clk,
    input  logic Rst_n,
    input  logic tag_in,
    output logic tag_out
);

    logic [PIPE_LAT-1:0] sr;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign tag_out = sr[PIPE_LAT-1];

endmodule

// File: rtl/fir_root_seq.sv
// Sequencer/configurator for the FIR -> ROOT datapath: coefficient banks, sample feed, result tagging.
// Optional result counter enabled with `define RESULT_CNT_EN.
module fir_root_seq
    import fir_root_pkg::*;
#(
    parameter int PIPE_LAT = 4
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [DW-1:0]      cfg_data,
    input  logic               cfg_commit,
    input  logic               flush_req,
    input  logic               s_valid,
    input  logic [DW-1:0]      s_data,
    output logic               s_ready,
    output logic [DW-1:0]      fir_x,
    output logic [TAPS*DW-1:0] fir_b,
    input  logic [DW-1:0]      fir_y,
    input  logic [3:0]         root_c,
    output logic               m_valid,
    output logic [DW-1:0]      m_fir,
    output logic [3:0]         m_root,
    output logic               busy,
    output logic [15:0]        out_count,
    output state_t             state_dbg
);

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
    // s_ready depends only on registered state, and s_data must be stable while s_valid is high.

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       flush_pend, commit_pend;
    logic       x_tag, tag_out;
    logic       accept, flush_last, drain_last, drain_done, swap;
    coef_t      shadow [TAPS];
    coef_t      active [TAPS];

    assign s_ready    = (state == ST_RUN) && !flush_pend && !commit_pend;
    assign accept     = s_valid && s_ready;
    assign busy       = (state != ST_RUN);
    assign state_dbg  = state;
    assign flush_last = (cnt == 4'(TAPS - 1));
    assign drain_last = (cnt == 4'(PIPE_LAT - 1));
    assign drain_done = (state == ST_DRAIN) && drain_last;
    assign swap       = drain_done && commit_pend;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_RUN: begin
                cnt_next = '0;
                if (flush_pend) begin
                    state_next = ST_FLUSH;
                end else if (commit_pend) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (flush_last) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_RUN;
            cnt         <= '0;
            flush_pend  <= 1'b0;
            commit_pend <= 1'b0;
            fir_x       <= '0;
            x_tag       <= 1'b0;
            m_valid     <= 1'b0;
            m_fir       <= '0;
            m_root      <= '0;
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // A request landing in the final drain cycle survives and triggers another pass.
            flush_pend  <= flush_req  ? 1'b1 : (drain_done ? 1'b0 : flush_pend);
            commit_pend <= cfg_commit ? 1'b1 : (drain_done ? 1'b0 : commit_pend);

            if (accept) begin
                fir_x <= s_data;
                x_tag <= 1'b1;
            end else begin
                x_tag <= 1'b0;
                if (state_next != ST_RUN) begin
                    fir_x <= '0;
                end
            end

            m_valid <= tag_out;
            m_fir   <= fir_y;
            m_root  <= root_c;

            // active samples shadow before this cycle's write lands
            for (int i = 0; i < TAPS; i++) begin
                if (swap) begin
                    active[i] <= shadow[i];
                end
                if (cfg_we && (cfg_addr == 3'(i))) begin
                    shadow[i] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        fir_b = '0;
        for (int i = 0; i < TAPS; i++) begin
            fir_b[i*DW +: DW] = active[i];
        end
    end

    fir_root_vld_pipe #(.PIPE_LAT(PIPE_LAT)) u_vld_pipe (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .tag_in  (x_tag),
        .tag_out (tag_out)
    );

`ifdef RESULT_CNT_EN
    logic [15:0] res_cnt;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            res_cnt <= '0;
        end else if (swap) begin
            res_cnt <= '0;
        end else if (m_valid) begin
            res_cnt <= res_cnt + 16'd1;
        end
    end

    assign out_count = res_cnt;
`else
    assign out_count = '0;
`endif

endmodule
